// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if: mode-logic <-> scan sequencer signals for the 8-digit display.
interface digit_scan_ctrl_if;
    logic       enable;
    logic [7:0] digit_en;
    logic [7:0] blink_en;
    logic       blink_tick;
    logic       rotate;
    logic [2:0] sel;
    logic [7:0] an_n;
    logic       frame_start;
    modport master (output enable, digit_en, blink_en, blink_tick, input rotate, sel, an_n, frame_start);
    modport slave (input enable, digit_en, blink_en, blink_tick, output rotate, sel, an_n, frame_start);
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: blanked, skipping, blinking scan sequencer for an 8-digit mux display.
// Optional blink support is compiled in with the SCAN_BLINK_EN macro.
module digit_scan_ctrl #(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input logic clk,
    input logic rst,
    digit_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYC - 1);
    localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
    state_t      r_state;
    logic [31:0] r_cnt;
    logic [2:0]  r_sel;
    logic        r_rotate;
    logic [7:0]  r_an_n;
    logic        r_frame_start;
    logic        r_phase;
    logic [2:0]  w_sel;
    logic        w_blink;
    logic [7:0]  w_lit;
    // The external counter advances on the edge ending a rotate cycle, so decisions use the post-edge select.
    always_comb begin
        w_sel = r_sel + {2'b00, r_rotate};
`ifdef SCAN_BLINK_EN
        w_blink = r_phase & bus.blink_en[w_sel];
`else
        w_blink = 1'b0;
`endif
        w_lit = w_blink ? 8'hFF : ~(8'h01 << w_sel);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_sel         <= '0;
            r_rotate      <= 1'b0;
            r_an_n        <= 8'hFF;
            r_frame_start <= 1'b0;
            r_phase       <= 1'b0;
        end else begin
            r_sel         <= w_sel;
            r_frame_start <= r_rotate && r_sel == 3'd7;
`ifdef SCAN_BLINK_EN
            r_phase       <= r_phase ^ bus.blink_tick;
`else
            r_phase       <= 1'b0;
`endif
            r_rotate      <= 1'b0;
            r_an_n        <= 8'hFF;
            if (!bus.enable) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= BLANK;
                        r_cnt   <= '0;
                    end
                    BLANK: begin
                        // Once expired the counter holds, giving one skip per cycle.
                        if (r_cnt != BLANK_LAST) r_cnt <= r_cnt + 32'd1;
                        else if (bus.digit_en[w_sel]) begin
                            r_state <= SHOW;
                            r_cnt   <= '0;
                            r_an_n  <= w_lit;
                        end else if (|bus.digit_en) r_rotate <= 1'b1;
                    end
                    SHOW: begin
                        if (r_cnt == TICK_LAST) begin
                            r_state <= BLANK;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt    <= r_cnt + 32'd1;
                            r_an_n   <= w_lit;
                            r_rotate <= r_cnt == TICK_LAST - 32'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
    assign bus.rotate      = r_rotate;
    assign bus.sel         = r_sel;
    assign bus.an_n        = r_an_n;
    assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: vector table plus directed sequences for digit_scan_ctrl (TICK_DIV=4, BLANK_CYC=2).
module tb_digit_scan_ctrl;
    typedef struct {
        logic       r;
        logic       en;
        logic [7:0] de;
        logic       rot;
        logic [2:0] sel;
        logic [7:0] an;
        logic       fs;
    } vec_t;
`ifdef SCAN_BLINK_EN
    localparam logic [7:0] BLK = 8'hFF;
`else
    localparam logic [7:0] BLK = 8'hFE;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    vec_t tv[25];
    digit_scan_ctrl_if bus ();
    digit_scan_ctrl #(.TICK_DIV(4), .BLANK_CYC(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic step(input logic r, input logic en, input logic [7:0] de, input logic [7:0] be, input logic bt);
        rst = r;
        bus.enable = en;
        bus.digit_en = de;
        bus.blink_en = be;
        bus.blink_tick = bt;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    initial begin
        int t1, t2, nrot, cyc;
        logic [8:0] rots;
        logic found;
        bus.enable = 1'b0;
        bus.digit_en = 8'hFF;
        bus.blink_en = 8'h00;
        bus.blink_tick = 1'b0;
        tv[0]  = '{1, 0, 8'hFF, 0, 0, 8'hFF, 0};
        tv[1]  = '{0, 1, 8'hFF, 0, 0, 8'hFF, 0};
        tv[2]  = '{0, 1, 8'hFF, 0, 0, 8'hFF, 0};
        tv[3]  = '{0, 1, 8'hFF, 0, 0, 8'hFE, 0};
        tv[4]  = '{0, 1, 8'hFF, 0, 0, 8'hFE, 0};
        tv[5]  = '{0, 1, 8'hFF, 0, 0, 8'hFE, 0};
        tv[6]  = '{0, 1, 8'hFF, 1, 0, 8'hFE, 0};
        tv[7]  = '{0, 1, 8'hFF, 0, 1, 8'hFF, 0};
        tv[8]  = '{0, 1, 8'hFF, 0, 1, 8'hFF, 0};
        tv[9]  = '{0, 1, 8'hFF, 0, 1, 8'hFD, 0};
        tv[10] = '{0, 1, 8'hFF, 0, 1, 8'hFD, 0};
        tv[11] = '{0, 1, 8'hFF, 0, 1, 8'hFD, 0};
        tv[12] = '{0, 1, 8'hFF, 1, 1, 8'hFD, 0};
        tv[13] = '{0, 0, 8'hFF, 0, 2, 8'hFF, 0};
        tv[14] = '{1, 0, 8'hFF, 0, 0, 8'hFF, 0};
        tv[15] = '{0, 1, 8'hFF, 0, 0, 8'hFF, 0};
        tv[16] = '{0, 1, 8'hFF, 0, 0, 8'hFF, 0};
        tv[17] = '{0, 1, 8'hFF, 0, 0, 8'hFE, 0};
        tv[18] = '{0, 1, 8'hFF, 0, 0, 8'hFE, 0};
        tv[19] = '{0, 1, 8'hFF, 0, 0, 8'hFE, 0};
        tv[20] = '{0, 0, 8'hFF, 0, 0, 8'hFF, 0};
        tv[21] = '{0, 0, 8'hFF, 0, 0, 8'hFF, 0};
        tv[22] = '{0, 1, 8'hFF, 0, 0, 8'hFF, 0};
        tv[23] = '{0, 1, 8'hFF, 0, 0, 8'hFF, 0};
        tv[24] = '{0, 1, 8'hFF, 0, 0, 8'hFE, 0};
        for (int i = 0; i < 25; i++) begin
            step(tv[i].r, tv[i].en, tv[i].de, 8'h00, 1'b0);
            chk($sformatf("vec%0d_rotate", i), int'(bus.rotate), int'(tv[i].rot));
            chk($sformatf("vec%0d_sel", i), int'(bus.sel), int'(tv[i].sel));
            chk($sformatf("vec%0d_an_n", i), int'(bus.an_n), int'(tv[i].an));
            chk($sformatf("vec%0d_frame_start", i), int'(bus.frame_start), int'(tv[i].fs));
        end
        // Frame length and frame_start alignment
        step(1, 0, 8'hFF, 8'h00, 0);
        t1 = -1; t2 = -1; nrot = 0;
        for (int c = 1; c <= 200 && t2 < 0; c++) begin
            step(0, 1, 8'hFF, 8'h00, 0);
            if (t1 >= 0 && bus.rotate) nrot++;
            if (bus.frame_start) begin
                if (t1 < 0) begin
                    t1 = c;
                    chk("frame_sel_at_start", int'(bus.sel), 0);
                end else t2 = c;
            end
        end
        chk("first_frame_start_cycle", t1, 49);
        chk("frame_length", t2 - t1, 48);
        chk("rotates_per_frame", nrot, 8);
        step(0, 1, 8'hFF, 8'h00, 0);
        chk("frame_start_one_cycle", int'(bus.frame_start), 0);
        // Skip run over digits 1..6
        step(1, 0, 8'h81, 8'h00, 0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step(0, 1, 8'h81, 8'h00, 0);
            found = bus.rotate;
        end
        chk("skip_first_rotate_seen", int'(found), 1);
        for (int k = 0; k < 9; k++) begin
            step(0, 1, 8'h81, 8'h00, 0);
            rots[k] = bus.rotate;
            if (k == 7) chk("skip_sel_before_last", int'(bus.sel), 6);
        end
        chk("skip_rotate_pattern", int'(rots), int'(9'b0_1111_1100));
        chk("skip_sel_final", int'(bus.sel), 7);
        chk("skip_an_final", int'(bus.an_n), 8'h7F);
        // All digits disabled, then digit 2 only
        step(1, 0, 8'h00, 8'h00, 0);
        cyc = 0;
        for (int c = 0; c < 30; c++) begin
            step(0, 1, 8'h00, 8'h00, 0);
            if (bus.rotate || bus.an_n != 8'hFF) cyc++;
        end
        chk("all_disabled_dark_cycles", cyc, 0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step(0, 1, 8'h04, 8'h00, 0);
            found = bus.an_n == 8'hFB;
        end
        chk("resume_digit2_lit", int'(found), 1);
        chk("resume_digit2_sel", int'(bus.sel), 2);
        // Mid-operation reset during digit 5
        step(1, 0, 8'hFF, 8'h00, 0);
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step(0, 1, 8'hFF, 8'h00, 0);
            found = bus.sel == 3'd5 && bus.an_n == 8'hDF;
        end
        chk("midreset_reached_digit5", int'(found), 1);
        step(1, 1, 8'hFF, 8'h00, 0);
        chk("midreset_sel", int'(bus.sel), 0);
        chk("midreset_an", int'(bus.an_n), 8'hFF);
        chk("midreset_rotate", int'(bus.rotate), 0);
        step(0, 1, 8'hFF, 8'h00, 0);
        chk("midreset_blank1", int'(bus.an_n), 8'hFF);
        step(0, 1, 8'hFF, 8'h00, 0);
        chk("midreset_blank2", int'(bus.an_n), 8'hFF);
        step(0, 1, 8'hFF, 8'h00, 0);
        chk("midreset_relit", int'(bus.an_n), 8'hFE);
        // Blink on digit 0, second tick mid-slot restores it
        step(1, 0, 8'hFF, 8'h01, 0);
        step(0, 1, 8'hFF, 8'h01, 1);
        step(0, 1, 8'hFF, 8'h01, 0);
        chk("blink_blank", int'(bus.an_n), 8'hFF);
        step(0, 1, 8'hFF, 8'h01, 0);
        chk("blink_lit1", int'(bus.an_n), int'(BLK));
        step(0, 1, 8'hFF, 8'h01, 1);
        chk("blink_lit2", int'(bus.an_n), int'(BLK));
        chk("blink_lit2_rotate", int'(bus.rotate), 0);
        step(0, 1, 8'hFF, 8'h01, 0);
        chk("blink_restored3", int'(bus.an_n), 8'hFE);
        step(0, 1, 8'hFF, 8'h01, 0);
        chk("blink_restored4", int'(bus.an_n), 8'hFE);
        chk("blink_slot_rotate", int'(bus.rotate), 1);
        step(0, 1, 8'hFF, 8'h01, 0);
        step(0, 1, 8'hFF, 8'h01, 0);
        step(0, 1, 8'hFF, 8'h01, 0);
        chk("blink_next_digit", int'(bus.an_n), 8'hFD);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
